// File: rtl/cru_master.sv
// cru_master: CRU bus initiator for SBO/SBZ, TB, LDCR and STCR, one command at a time.
// Define CRU_PARITY_EN to report the odd parity of the transferred bits on rsp_parity.
module cru_master #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [11:0] cmd_addr,
    input  logic [3:0]  cmd_count,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_parity,
    output logic [11:0] cru_addr,
    output logic        cru_dout,
    input  logic        cru_din,
    output logic        cruclk
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || SETUP_CYC > 256) begin : g_bad_setup
        $error("cru_master: SETUP_CYC must be 1..256");
    end
    if (PULSE_CYC < 1 || PULSE_CYC > 256) begin : g_bad_pulse
        $error("cru_master: PULSE_CYC must be 1..256");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 256) begin : g_bad_hold
        $error("cru_master: HOLD_CYC must be 1..256");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       last_q, last_d;
    logic             is_read_q, is_read_d;
    logic [11:0]      base_q, base_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [11:0]      cru_addr_q, cru_addr_d;
    logic             cru_dout_q, cru_dout_d;
    logic             cruclk_q, cruclk_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             accept;
    logic             bit_done;

    assign cmd_ready = (state_q == ST_IDLE) && n_reset;
    assign accept    = (state_q == ST_IDLE) && cmd_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        last_d      = last_q;
        is_read_d   = is_read_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cru_addr_d  = cru_addr_q;
        cru_dout_d  = cru_dout_q;
        rsp_valid_d = 1'b0;
        bit_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SETUP;
                    cnt_d      = SETUP_LD;
                    is_read_d  = cmd_op[0];
                    base_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    idx_d      = 4'd0;
                    // count 0 wraps to last index 15, i.e. 16 bits
                    last_d     = cmd_op[1] ? (cmd_count - 4'd1) : 4'd0;
                    cru_addr_d = cmd_addr;
                    cru_dout_d = cmd_op[0] ? 1'b0 : cmd_wdata[0];
                    rdata_d    = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (is_read_q) begin
                    rdata_d[idx_q] = cru_din;
                    bit_done       = 1'b1;
                end else begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    bit_done = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus address and data move only here or on accept, never mid-strobe.
        if (bit_done) begin
            if (idx_q == last_q) begin
                state_d     = ST_DONE;
                rsp_valid_d = 1'b1;
            end else begin
                idx_d      = idx_q + 4'd1;
                cru_addr_d = base_q + {8'd0, idx_d};
                cru_dout_d = is_read_q ? 1'b0 : wdata_q[idx_d];
                state_d    = ST_SETUP;
                cnt_d      = SETUP_LD;
            end
        end

        cruclk_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            is_read_q   <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cru_addr_q  <= '0;
            cru_dout_q  <= 1'b0;
            cruclk_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            is_read_q   <= is_read_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cru_addr_q  <= cru_addr_d;
            cru_dout_q  <= cru_dout_d;
            cruclk_q    <= cruclk_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef CRU_PARITY_EN
    logic parity_q, parity_d;
    logic bit_val;

    // Running XOR of each bit as it completes; final value is ready in DONE.
    always_comb begin
        bit_val  = is_read_q ? cru_din : wdata_q[idx_q];
        parity_d = parity_q;
        if (accept) begin
            parity_d = 1'b0;
        end else if (bit_done) begin
            parity_d = parity_q ^ bit_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign rsp_parity = parity_q;
`else
    assign rsp_parity = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign cru_addr  = cru_addr_q;
    assign cru_dout  = cru_dout_q;
    assign cruclk    = cruclk_q;

endmodule

// File: tb/tb_cru_master.sv
// tb_cru_master: table vectors, hand-written reset/back-to-back sequences and random
// commands checked against a bit-level reference model of the CRU transfer rules.
module tb_cru_master;

    localparam int S = 2;
    localparam int P = 2;
    localparam int H = 1;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [3:0]  cmd_count;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_parity;
    logic [11:0] cru_addr;
    logic        cru_dout;
    logic        cru_din;
    logic        cruclk;

    int n_checks = 0;
    int n_errors = 0;

    bit resp_mem [4096];
    assign cru_din = resp_mem[cru_addr];

    always #5 clk = ~clk;

    cru_master #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk(clk), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_parity(rsp_parity),
        .cru_addr(cru_addr), .cru_dout(cru_dout), .cru_din(cru_din), .cruclk(cruclk)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bus monitor: records every cruclk pulse and flags address/data moving
    // too close to or during a strobe.
    int unsigned q_addr[$];
    bit          q_dout[$];
    int          q_len[$];
    int          m_viol = 0;
    int          m_stable = 0;
    int          m_low_run = 0;
    logic [11:0] m_addr_p = '0;
    logic        m_dout_p = 1'b0;
    logic        m_clk_p = 1'b0;

    always @(posedge clk) begin : mon
        bit changed;
        int last;
        #1;
        if (n_reset) begin
            changed = (cru_addr !== m_addr_p) || (cru_dout !== m_dout_p);
            if (cruclk) begin
                if (!m_clk_p) begin
                    q_addr.push_back(cru_addr);
                    q_dout.push_back(cru_dout);
                    q_len.push_back(1);
                    if (changed || m_stable < S) m_viol++;
                end else begin
                    last = q_len.size() - 1;
                    if (last >= 0) q_len[last] = q_len[last] + 1;
                    if (changed) m_viol++;
                end
                m_low_run = 0;
            end else begin
                if (changed && m_clk_p) m_viol++;
                else if (changed && q_len.size() > 0 && m_low_run < H) m_viol++;
                m_low_run++;
            end
            m_stable = changed ? 1 : m_stable + 1;
        end
        m_addr_p = cru_addr;
        m_dout_p = cru_dout;
        m_clk_p  = cruclk;
    end

    function automatic int model_n(input logic [1:0] op, input logic [3:0] cnt);
        if (!op[1]) return 1;
        return (cnt == 4'd0) ? 16 : int'(cnt);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after the response.
    task automatic run_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [3:0] cnt,
                           input logic [15:0] wd, output int lat, output logic [15:0] rd,
                           output logic par);
        int n, exp_lat, ones, a, np;
        bit is_rd, b;
        logic [15:0] exp_rd;
        logic exp_par;
        n = model_n(op, cnt);
        is_rd = op[0];
        exp_lat = n * (is_rd ? S : (S + P + H));
        exp_rd = '0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            a = (int'(addr) + i) % 4096;
            b = is_rd ? resp_mem[a] : wd[i];
            if (is_rd) exp_rd[i] = b;
            ones += int'(b);
        end
`ifdef CRU_PARITY_EN
        exp_par = (ones % 2) == 1;
`else
        exp_par = 1'b0;
`endif
        q_addr.delete(); q_dout.delete(); q_len.delete(); m_viol = 0;
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_count = cnt; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = 12'($urandom); cmd_count = 4'($urandom);
        cmd_wdata = 16'($urandom);
        check("addr_on_accept", {20'd0, cru_addr}, {20'd0, addr});
        check("dout_on_accept", {31'd0, cru_dout}, {31'd0, is_rd ? 1'b0 : wd[0]});
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        rd = rsp_rdata;
        par = rsp_parity;
        check("latency", lat, exp_lat);
        check("rdata", {16'd0, rd}, {16'd0, exp_rd});
        check("parity", {31'd0, par}, {31'd0, exp_par});
        check("ready_in_done", {31'd0, cmd_ready}, 32'd0);
        np = q_addr.size();
        check("pulse_count", np, is_rd ? 0 : n);
        if (np > n) np = n;
        for (int j = 0; j < np; j++) begin
            check("pulse_addr", q_addr[j], (int'(addr) + j) % 4096);
            check("pulse_dout", {31'd0, q_dout[j]}, {31'd0, wd[j]});
            check("pulse_len", q_len[j], P);
        end
        check("bus_timing", m_viol, 0);
        @(negedge clk);
        check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
        check("rdata_hold", {16'd0, rsp_rdata}, {16'd0, exp_rd});
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [3:0]  cnt;
        logic [15:0] wd;
        logic [15:0] rpat;
        int          lat;
        logic [15:0] rdata;
        logic        par_on;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int lat, hi, nv;
        logic [15:0] rd;
        logic par, exp_par;
        logic [1:0] op;
        logic [11:0] addr;

        vecs[0] = '{2'b00, 12'h003, 4'd0, 16'h0001, 16'h0000, 5,  16'h0000, 1'b1};
        vecs[1] = '{2'b00, 12'h123, 4'd7, 16'hFFFE, 16'h0000, 5,  16'h0000, 1'b0};
        vecs[2] = '{2'b01, 12'h002, 4'd0, 16'hFFFF, 16'hFFFE, 2,  16'h0000, 1'b0};
        vecs[3] = '{2'b01, 12'h7FF, 4'd3, 16'h0000, 16'h0001, 2,  16'h0001, 1'b1};
        vecs[4] = '{2'b10, 12'h010, 4'd8, 16'h00A5, 16'h0000, 40, 16'h0000, 1'b0};
        vecs[5] = '{2'b11, 12'h000, 4'd0, 16'h0000, 16'hB234, 32, 16'hB234, 1'b1};
        vecs[6] = '{2'b10, 12'hFFE, 4'd4, 16'h000F, 16'h0000, 20, 16'h0000, 1'b0};
        vecs[7] = '{2'b11, 12'hFFD, 4'd5, 16'h0000, 16'h0035, 10, 16'h0015, 1'b1};
        vecs[8] = '{2'b10, 12'h5A5, 4'd1, 16'hFFFE, 16'h0000, 5,  16'h0000, 1'b0};

        n_reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_count = '0;
        cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cruclk", {31'd0, cruclk}, 32'd0);
        check("rst_addr", {20'd0, cru_addr}, 32'd0);
        check("rst_dout", {31'd0, cru_dout}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_parity", {31'd0, rsp_parity}, 32'd0);
        check("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        n_reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        foreach (vecs[v]) begin
            for (int i = 0; i < 16; i++) resp_mem[(int'(vecs[v].addr) + i) % 4096] = vecs[v].rpat[i];
            run_cmd(vecs[v].op, vecs[v].addr, vecs[v].cnt, vecs[v].wd, lat, rd, par);
`ifdef CRU_PARITY_EN
            exp_par = vecs[v].par_on;
`else
            exp_par = 1'b0;
`endif
            check("vec_latency", lat, vecs[v].lat);
            check("vec_rdata", {16'd0, rd}, {16'd0, vecs[v].rdata});
            check("vec_parity", {31'd0, par}, {31'd0, exp_par});
        end

        // Reset during the third cruclk-high cycle of an LDCR.
        resp_mem[0] = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 12'h040; cmd_count = 4'd8;
        cmd_wdata = 16'hFFFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        hi = 0;
        for (int k = 0; k < 100 && hi < 3; k++) begin
            @(negedge clk);
            if (cruclk) hi++;
        end
        check("third_high_seen", hi, 3);
        check("third_high_addr", {20'd0, cru_addr}, 32'h041);
        n_reset = 1'b0;
        @(negedge clk);
        check("midrst_cruclk", {31'd0, cruclk}, 32'd0);
        check("midrst_addr", {20'd0, cru_addr}, 32'd0);
        check("midrst_dout", {31'd0, cru_dout}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        n_reset = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
        nv = 0;
        for (int k = 0; k < 60; k++) begin
            if (rsp_valid || cruclk) nv++;
            @(negedge clk);
        end
        check("midrst_no_activity", nv, 0);

        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom);
            addr = (t % 5 == 0) ? 12'($urandom_range(4080, 4095)) : 12'($urandom);
            for (int i = 0; i < 16; i++) resp_mem[(int'(addr) + i) % 4096] = 1'($urandom);
            run_cmd(op, addr, 4'($urandom), 16'($urandom), lat, rd, par);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/cru_master.md
# cru_master

CRU bus initiator: executes CPU-side CRU operations (single-bit set/reset, test bit, multi-bit load and store) by driving bit address, output data and `cruclk` toward CRU responders such as the 9901 interface block, and by sampling their returned bit. It sits between the CPU core's execute stage and the shared CRU bus. It accepts one command at a time over a valid/ready handshake and returns one response pulse per command.

## Interface
Parameters:
- SETUP_CYC, 2, cycles address/data are stable before `cruclk` rises; for reads, cycles before sampling (≥1)
- PULSE_CYC, 2, cycles `cruclk` is held high per written bit (≥1)
- HOLD_CYC, 1, cycles address/data are held after `cruclk` falls (≥1)

Ports:
- clk  in  1  clock
- n_reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE with n_reset high
- cmd_op  in  2  00 single write (SBO/SBZ), 01 test bit (TB), 10 multi write (LDCR), 11 multi read (STCR)
- cmd_addr  in  12  base CRU bit address
- cmd_count  in  4  bit count for LDCR/STCR, 0 means 16; ignored for single ops (count 1)
- cmd_wdata  in  16  write data, bit i goes to address base+i
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read bits, bit i from base+i, unread bits 0
- rsp_parity  out  1  odd-parity flag (see Configuration)
- cru_addr  out  12  bit address to responders
- cru_dout  out  1  data to responders (their `cruin`)
- cru_din  in  1  data from responders (their `cruout`; 1 when nothing is selected)
- cruclk  out  1  write strobe, active high

## Operation
- States: IDLE, SETUP, PULSE, HOLD, DONE.
- Accept: `cmd_valid & cmd_ready` at an edge. Latch op, address and data; set bit index i=0 and N = count (0→16, single ops→1); set `cru_addr`=base, `cru_dout`=wdata[0] for writes or 0 for reads; clear rsp_rdata; go to SETUP.
- SETUP runs SETUP_CYC cycles.
  - Write: then PULSE.
  - Read: on the closing edge of the last SETUP cycle, rdata[i] <= cru_din; then advance.
- PULSE: `cruclk`=1 for PULSE_CYC cycles, then HOLD with `cruclk`=0.
- HOLD runs HOLD_CYC cycles, then advance.
- Advance:
  - If i==N-1: go to DONE.
  - Otherwise: i++, `cru_addr`=(base+i) mod 4096, `cru_dout`=wdata[i] (0 for reads), go to SETUP.
- Address wraps 0xFFF→0x000 with no side effect.
- DONE lasts 1 cycle: `rsp_valid`=1 with rsp_rdata and rsp_parity stable, cmd_ready=0. Then IDLE.
- rsp_rdata holds its value until the next accept.
- Reads never pulse `cruclk`. `cru_addr` and `cru_dout` change only on advance or accept, never while `cruclk`=1 or in HOLD.
- Reset (any state, including mid-pulse), on that edge:
  - state IDLE, `cruclk`=0, cru_addr=0, cru_dout=0, rsp_valid=0, rsp_rdata=0, rsp_parity=0.
  - The aborted command produces no response.

## Timing
- All outputs registered except cmd_ready (decoded from state and n_reset).
- The first bus address appears on the accept edge.
- Write of N bits: rsp_valid high N×(SETUP_CYC+PULSE_CYC+HOLD_CYC) edges after accept. Default 5 per bit: SBO → 5, LDCR 8 → 40.
- Read of N bits: rsp_valid high N×SETUP_CYC edges after accept. Default TB → 2, STCR 16 → 32.
- Responders see `cruclk` rise with address and data already stable ≥SETUP_CYC cycles, and stable ≥HOLD_CYC cycles after the fall. This tolerates a responder that edge-detects `cruclk` one cycle late.
- Back-to-back: next accept at the earliest on the edge after DONE (1 idle-ready cycle minimum).

## Configuration
- `CRU_PARITY_EN` defined: rsp_parity = XOR of the N transferred bits (wdata[N-1:0] for writes, sampled bits for reads), i.e. 1 when the count of ones is odd. Computed incrementally per bit and valid in DONE.
- Not defined: rsp_parity is constant 0 and the parity logic is removed; all other behaviour is identical.

## Test plan
- SBO addr 0x003, wdata[0]=1 → cru_addr=0x003, cru_dout=1, one `cruclk` pulse of 2 cycles starting 2 cycles after accept; rsp_valid at accept+5; no other pulses.
- LDCR count 8, addr 0x010, wdata 0x00A5 → 8 pulses at addresses 0x010..0x017 with cru_dout 1,0,1,0,0,1,0,1; rsp_valid at accept+40; rsp_parity 0 with macro.
- STCR count 0, addr 0x000, responder model returning bits of 0xB234 → no `cruclk` activity; rsp_rdata=0xB234 at accept+32; rsp_parity 1 with macro, 0 without.
- LDCR count 4, addr 0xFFE, wdata 0x000F → pulses at 0xFFE, 0xFFF, 0x000, 0x001, each with cru_dout=1.
- Reset asserted during the third `cruclk`-high cycle of an LDCR → `cruclk`=0 and cru_addr=0 on that edge; cmd_ready=1 the cycle after release; no rsp_valid.
- Integrated with the 9901 block: n_INT[2]=0, TB addr 2 → rsp_rdata[0]=0; SBO addr 2, then n_INT[2]=0 → 9901 n_intreq goes low.
